// File: rtl/oflow_pe_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oflow_pe_sched_pkg: shared state type and default sizes for the PE set scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package oflow_pe_sched_pkg;

  localparam int unsigned c_pe_num     = 24;
  localparam int unsigned c_bbox_cnt_w = 10;
  localparam int unsigned c_set_cnt_w  = 6;

  typedef enum logic [2:0] {
    PS_IDLE    = 3'd0,
    PS_REQ_SET = 3'd1,
    PS_RUN     = 3'd2,
    PS_NEXT    = 3'd3,
    PS_DONE    = 3'd4
  } pe_sched_st_t;

endpackage
`default_nettype wire

// File: rtl/oflow_pe_mask_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oflow_pe_mask_gen: remaining bbox count -> active-PE enable mask (combinational)
// Rev 1.0
// ---------------------------------------------------------------------------
module oflow_pe_mask_gen
  import oflow_pe_sched_pkg::*;
#(
  parameter int unsigned PE_NUM     = c_pe_num,
  parameter int unsigned BBOX_CNT_W = c_bbox_cnt_w
) (
  input  logic [BBOX_CNT_W-1:0] remain_i,
  output logic [PE_NUM-1:0]     mask_o
);

  // PE i is enabled while more than i bboxes remain; saturates at all ones.
  for (genvar i = 0; i < PE_NUM; i++) begin : g_bit
    assign mask_o[i] = (32'(remain_i) > 32'(i));
  end

endmodule
`default_nettype wire

// File: rtl/oflow_pe_set_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oflow_pe_set_scheduler: walks a frame's bboxes through the PE array one set at a time.
// Optional watchdog: define OFLOW_PE_WATCHDOG_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module oflow_pe_set_scheduler
  import oflow_pe_sched_pkg::*;
#(
  parameter int unsigned PE_NUM     = c_pe_num,
  parameter int unsigned BBOX_CNT_W = c_bbox_cnt_w,
  parameter int unsigned SET_CNT_W  = c_set_cnt_w,
  parameter int unsigned WD_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  start_pe,
  input  logic [BBOX_CNT_W-1:0] num_of_bbox_in_frame,
  input  logic                  new_set_from_dma,
  output logic                  ready_new_set,
  output logic [PE_NUM-1:0]     pe_en,
  output logic                  pe_start,
  input  logic [PE_NUM-1:0]     pe_done,
  output logic [SET_CNT_W-1:0]  set_idx,
  output logic [SET_CNT_W-1:0]  num_of_sets,
  output logic [BBOX_CNT_W-1:0] counter_of_remain_bboxes,
  output logic                  done_pe,
  output logic                  busy,
  output logic                  pe_timeout
);

  localparam logic [2:0] c_st_idle    = PS_IDLE;
  localparam logic [2:0] c_st_req_set = PS_REQ_SET;
  localparam logic [2:0] c_st_run     = PS_RUN;
  localparam logic [2:0] c_st_next    = PS_NEXT;
  localparam logic [2:0] c_st_done    = PS_DONE;

  if (WD_CYCLES == 0) begin : g_wd_cfg_check
    $error("WD_CYCLES must be non-zero");
  end

  logic [2:0]            state_q, state_d;
  logic [BBOX_CNT_W-1:0] remain_q, remain_d;
  logic [SET_CNT_W-1:0]  set_idx_q, set_idx_d;
  logic [SET_CNT_W-1:0]  n_sets_q, n_sets_d;
  logic [PE_NUM-1:0]     pe_en_q, pe_en_d;
  logic [PE_NUM-1:0]     acc_q, acc_d;
  logic                  pe_start_q, pe_start_d;
  logic [PE_NUM-1:0]     set_mask;
  logic [SET_CNT_W-1:0]  sets_of_frame;
  logic                  wd_expired;

  assign sets_of_frame = SET_CNT_W'((32'(num_of_bbox_in_frame) + PE_NUM - 1) / PE_NUM);

  oflow_pe_mask_gen #(
    .PE_NUM     (PE_NUM),
    .BBOX_CNT_W (BBOX_CNT_W)
  ) u_mask_gen (
    .remain_i (remain_d),
    .mask_o   (set_mask)
  );

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    set_idx_d  = set_idx_q;
    n_sets_d   = n_sets_q;
    acc_d      = '0;
    pe_start_d = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (start_pe) begin
          n_sets_d  = sets_of_frame;
          remain_d  = num_of_bbox_in_frame;
          set_idx_d = '0;
          state_d   = (num_of_bbox_in_frame != '0) ? c_st_req_set : c_st_done;
        end
      end
      c_st_req_set: begin
        if (new_set_from_dma) begin
          state_d    = c_st_run;
          pe_start_d = 1'b1;
        end
      end
      c_st_run: begin
        // Done bits of disabled PEs never reach the accumulator.
        acc_d = acc_q | (pe_done & pe_en_q);
        if (acc_d == pe_en_q) begin
          state_d = c_st_next;
        end else if (wd_expired) begin
          state_d = c_st_idle;
        end
      end
      c_st_next: begin
        remain_d = (32'(remain_q) >= PE_NUM) ? remain_q - BBOX_CNT_W'(PE_NUM) : '0;
        if (set_idx_q == n_sets_q - SET_CNT_W'(1)) begin
          state_d = c_st_done;
        end else begin
          set_idx_d = set_idx_q + SET_CNT_W'(1);
          state_d   = c_st_req_set;
        end
      end
      c_st_done: state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  // Mask is loaded on REQ_SET entry and held through RUN and NEXT.
  always_comb begin
    pe_en_d = pe_en_q;
    if (state_d == c_st_req_set) begin
      pe_en_d = set_mask;
    end else if (state_d == c_st_idle || state_d == c_st_done) begin
      pe_en_d = '0;
    end
  end

`ifdef OFLOW_PE_WATCHDOG_EN
  localparam int unsigned c_wd_w = $clog2(WD_CYCLES + 1);

  logic [c_wd_w-1:0] wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;

  assign wd_expired = (state_q == c_st_run) && (32'(wd_cnt_q) == WD_CYCLES - 1);

  always_comb begin
    wd_cnt_d  = (state_q == c_st_run && state_d == c_st_run) ? wd_cnt_q + c_wd_w'(1) : '0;
    timeout_d = timeout_q;
    if (state_q == c_st_idle && start_pe) begin
      timeout_d = 1'b0;
    end else if (wd_expired && state_d == c_st_idle) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign pe_timeout = timeout_q;
`else
  assign wd_expired = 1'b0;
  assign pe_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= c_st_idle;
      remain_q   <= '0;
      set_idx_q  <= '0;
      n_sets_q   <= '0;
      pe_en_q    <= '0;
      acc_q      <= '0;
      pe_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      set_idx_q  <= set_idx_d;
      n_sets_q   <= n_sets_d;
      pe_en_q    <= pe_en_d;
      acc_q      <= acc_d;
      pe_start_q <= pe_start_d;
    end
  end

  assign ready_new_set            = (state_q == c_st_req_set);
  assign done_pe                  = (state_q == c_st_done);
  assign busy                     = (state_q != c_st_idle);
  assign pe_start                 = pe_start_q;
  assign pe_en                    = pe_en_q;
  assign set_idx                  = set_idx_q;
  assign num_of_sets              = n_sets_q;
  assign counter_of_remain_bboxes = remain_q;

endmodule
`default_nettype wire

// File: tb/tb_oflow_pe_set_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_oflow_pe_set_scheduler: directed + randomized frames against a set-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_oflow_pe_set_scheduler;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        start_pe;
  logic [9:0]  num_of_bbox_in_frame;
  logic        new_set_from_dma;
  logic        ready_new_set;
  logic [23:0] pe_en;
  logic        pe_start;
  logic [23:0] pe_done;
  logic [5:0]  set_idx;
  logic [5:0]  num_of_sets;
  logic [9:0]  counter_of_remain_bboxes;
  logic        done_pe;
  logic        busy;
  logic        pe_timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  oflow_pe_set_scheduler #(
    .PE_NUM     (24),
    .BBOX_CNT_W (10),
    .SET_CNT_W  (6),
    .WD_CYCLES  (16)
  ) dut (
    .clk                      (clk),
    .reset_N                  (reset_N),
    .start_pe                 (start_pe),
    .num_of_bbox_in_frame     (num_of_bbox_in_frame),
    .new_set_from_dma         (new_set_from_dma),
    .ready_new_set            (ready_new_set),
    .pe_en                    (pe_en),
    .pe_start                 (pe_start),
    .pe_done                  (pe_done),
    .set_idx                  (set_idx),
    .num_of_sets              (num_of_sets),
    .counter_of_remain_bboxes (counter_of_remain_bboxes),
    .done_pe                  (done_pe),
    .busy                     (busy),
    .pe_timeout               (pe_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_pe === 1'b1) done_cnt++;
    if (pe_start === 1'b1) start_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},   ready_new_set, 0);
    chk({tag, "_pe_en"},   pe_en, 0);
    chk({tag, "_pe_start"}, pe_start, 0);
    chk({tag, "_set_idx"}, set_idx, 0);
    chk({tag, "_nsets"},   num_of_sets, 0);
    chk({tag, "_remain"},  counter_of_remain_bboxes, 0);
    chk({tag, "_done"},    done_pe, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_timeout"}, pe_timeout, 0);
  endtask

  // One frame: the model walks sets of up to 24 bboxes, derived only from N.
  task automatic run_frame(input int n, input int dma_dly, input int stagger, input bit mid_start);
    int nsets, rem, cnt, lat, pick, d0, s0;
    int arr[24];
    logic [23:0] mask, bits;
    nsets = (n + 23) / 24;
    d0 = done_cnt;
    s0 = start_cnt;
    num_of_bbox_in_frame = 10'(n);
    start_pe = 1'b1;
    cyc();
    start_pe = 1'b0;
    num_of_bbox_in_frame = 10'($urandom);
    chk("num_of_sets", num_of_sets, nsets);
    chk("busy_start", busy, 1);
    chk("timeout_cleared", pe_timeout, 0);
    if (n == 0) begin
      chk("done_n0", done_pe, 1);
      chk("ready_n0", ready_new_set, 0);
      chk("remain_n0", counter_of_remain_bboxes, 0);
    end
    for (int s = 0; s < nsets; s++) begin
      rem  = n - 24 * s;
      cnt  = (rem >= 24) ? 24 : rem;
      mask = (rem >= 24) ? 24'hFFFFFF : 24'((32'd1 << rem) - 32'd1);
      chk("ready_req", ready_new_set, 1);
      chk("pe_en_req", pe_en, mask);
      chk("remain_req", counter_of_remain_bboxes, rem);
      chk("set_idx_req", set_idx, s);
      chk("done_req", done_pe, 0);
      for (int k = 0; k < dma_dly; k++) begin
        start_pe = mid_start && (k == 0);
        num_of_bbox_in_frame = 10'($urandom_range(1, 100));
        pe_done = 24'($urandom);
        cyc();
        start_pe = 1'b0;
        pe_done = '0;
        chk("ready_hold", ready_new_set, 1);
        chk("pe_en_hold", pe_en, mask);
        chk("pe_start_wait", pe_start, 0);
        chk("set_idx_hold", set_idx, s);
      end
      new_set_from_dma = 1'b1;
      cyc();
      new_set_from_dma = 1'b0;
      chk("pe_start", pe_start, 1);
      chk("pe_en_run", pe_en, mask);
      chk("ready_run", ready_new_set, 0);
      lat = (stagger > 0) ? stagger * (cnt - 1) : int'($urandom_range(0, 6));
      for (int i = 0; i < cnt; i++) begin
        arr[i] = (stagger > 0) ? stagger * i : int'($urandom_range(0, lat));
      end
      if (stagger == 0) begin
        pick = int'($urandom_range(0, cnt - 1));
        arr[pick] = lat;
      end
      for (int k = 0; k <= lat; k++) begin
        if (k > 0) begin
          chk("ready_running", ready_new_set, 0);
          chk("pe_start_once", pe_start, 0);
          chk("done_running", done_pe, 0);
        end
        bits = '0;
        for (int i = 0; i < cnt; i++) if (arr[i] == k) bits[i] = 1'b1;
        pe_done = bits | ((stagger > 0) ? 24'h100000 : (24'($urandom) & ~mask));
        new_set_from_dma = 1'($urandom_range(0, 1));
        cyc();
      end
      pe_done = '0;
      new_set_from_dma = 1'b1;
      chk("ready_next", ready_new_set, 0);
      chk("done_next", done_pe, 0);
      chk("pe_start_next", pe_start, 0);
      cyc();
      new_set_from_dma = 1'b0;
      if (s == nsets - 1) begin
        chk("done_pe", done_pe, 1);
        chk("remain_done", counter_of_remain_bboxes, 0);
        chk("ready_done", ready_new_set, 0);
      end
    end
    cyc();
    chk("busy_after", busy, 0);
    chk("done_after", done_pe, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("pe_start_count", start_cnt - s0, nsets);
  endtask

  initial begin
    reset_N = 1'b0;
    start_pe = 1'b0;
    num_of_bbox_in_frame = '0;
    new_set_from_dma = 1'b0;
    pe_done = '0;
    #1;
    chk_all_zero("reset");
    cyc();
    cyc();
    reset_N = 1'b1;
    cyc();
    chk_all_zero("idle");

    run_frame(50, 0, 0, 1'b0);
    run_frame(24, 0, 0, 1'b0);
    run_frame(0, 0, 0, 1'b0);
    run_frame(5, 1, 2, 1'b0);
    run_frame(60, 7, 0, 1'b1);
    run_frame(1023, 1, 0, 1'b0);

`ifdef OFLOW_PE_WATCHDOG_EN
    begin
      int d0;
      d0 = done_cnt;
      num_of_bbox_in_frame = 10'd5;
      start_pe = 1'b1;
      cyc();
      start_pe = 1'b0;
      new_set_from_dma = 1'b1;
      cyc();
      new_set_from_dma = 1'b0;
      pe_done = 24'h00000F;
      cyc();
      pe_done = '0;
      repeat (14) cyc();
      chk("wd_busy_before", busy, 1);
      chk("wd_flag_before", pe_timeout, 0);
      cyc();
      chk("wd_flag", pe_timeout, 1);
      chk("wd_idle", busy, 0);
      cyc();
      chk("wd_flag_sticky", pe_timeout, 1);
      chk("wd_no_done", done_cnt - d0, 0);
    end
`endif

    num_of_bbox_in_frame = 10'd30;
    start_pe = 1'b1;
    cyc();
    start_pe = 1'b0;
    new_set_from_dma = 1'b1;
    cyc();
    new_set_from_dma = 1'b0;
    pe_done = 24'h000FFF;
    cyc();
    pe_done = '0;
    #1;
    reset_N = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    cyc();
    reset_N = 1'b1;
    cyc();
    run_frame(30, 1, 0, 1'b0);

    for (int f = 0; f < 15; f++) begin
      run_frame(int'($urandom_range(0, 150)), int'($urandom_range(1, 4)), 0,
                1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
